ft_tx_scheduler: RTL

//  Sequences 16-bit words into the FT245 bridge TX port (ui_din*) in the clk_128M domain.
//  Two requesters: decoded telemetry packets (88-bit) and periodic link-status snapshots.

---
 rtl/ft_tx_scheduler_if.sv | 21 ++
 rtl/ft_tx_scheduler.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ft_tx_scheduler_if.sv
// FT245 bridge TX word port: 16-bit data, byte enables, valid, and FIFO-full backpressure.
interface ft_tx_scheduler_if;
  logic [15:0] ui_din;
  logic [1:0]  ui_din_be;
  logic        ui_din_valid;
  logic        ui_din_full;

  modport master (
    output ui_din,
    output ui_din_be,
    output ui_din_valid,
    input  ui_din_full
  );

  modport slave (
    input  ui_din,
    input  ui_din_be,
    input  ui_din_valid,
    output ui_din_full
  );
endinterface

// File: rtl/ft_tx_scheduler.sv
// Frames telemetry packets and periodic link-status snapshots onto the FT245 TX word port.
// Optional trailing checksum word per frame when FT_TX_SCHED_CHECKSUM_EN is defined.
module ft_tx_scheduler #(
  parameter logic [31:0] STATUS_PERIOD = 32'd12_800_000,
  parameter logic [15:0] TLM_HEADER    = 16'hA501,
  parameter logic [15:0] STS_HEADER    = 16'hA502
) (
  input  logic                     clk_128M,
  input  logic                     rst_128M,
  input  logic [87:0]              packet_data,
  input  logic                     packet_valid,
  input  logic [31:0]              total_packets,
  input  logic [31:0]              mismatch_packets,
  ft_tx_scheduler_if.master        tx,
  output logic [15:0]              drop_count,
  output logic                     busy
);

`ifdef FT_TX_SCHED_CHECKSUM_EN
  typedef enum logic [1:0] {StIdle, StSendTlm, StSendSts, StSendCsum} state_e;
`else
  typedef enum logic [1:0] {StIdle, StSendTlm, StSendSts} state_e;
`endif

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [87:0] frame_q, frame_d;
  logic        ftype_q, ftype_d;     // 0: telemetry, 1: status
  logic        rr_q, rr_d;           // type of the most recent grant
  logic        buf_full_q, buf_full_d;
  logic [87:0] buf_q, buf_d;
  logic        sts_pend_q, sts_pend_d;
  logic [31:0] period_q, period_d;
  logic [15:0] drop_q, drop_d;
  logic [15:0] dout_q, dout_d;
  logic        dvalid_q, dvalid_d;
`ifdef FT_TX_SCHED_CHECKSUM_EN
  logic [15:0] csum_q, csum_d;
`endif

  logic        load_ok;
  logic        pick_sts;
  logic        grant_tlm;
  logic        grant_sts;
  logic        emit;
  logic [15:0] emit_word;
  logic [15:0] cur_word;
  logic [2:0]  last_idx;
  logic        timer_tc;

  assign load_ok  = !dvalid_q || !tx.ui_din_full;
  assign pick_sts = sts_pend_q && (!buf_full_q || !rr_q);
  assign last_idx = ftype_q ? 3'd5 : 3'd6;
  assign timer_tc = (STATUS_PERIOD != 32'd0) && (period_q == STATUS_PERIOD - 32'd1);

  // Status frames reuse the telemetry word slicing: frame_q = {8'h00, drop, mis, tot}.
  always_comb begin
    cur_word = 16'h0000;
    case (idx_q)
      3'd0:    cur_word = ftype_q ? STS_HEADER : TLM_HEADER;
      3'd1:    cur_word = frame_q[15:0];
      3'd2:    cur_word = frame_q[31:16];
      3'd3:    cur_word = frame_q[47:32];
      3'd4:    cur_word = frame_q[63:48];
      3'd5:    cur_word = frame_q[79:64];
      default: cur_word = {8'h00, frame_q[87:80]};
    endcase
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    frame_d   = frame_q;
    ftype_d   = ftype_q;
    rr_d      = rr_q;
    grant_tlm = 1'b0;
    grant_sts = 1'b0;
    emit      = 1'b0;
    emit_word = 16'h0000;
`ifdef FT_TX_SCHED_CHECKSUM_EN
    csum_d    = csum_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (buf_full_q || sts_pend_q) begin
          ftype_d   = pick_sts;
          rr_d      = pick_sts;
          grant_sts = pick_sts;
          grant_tlm = !pick_sts;
          frame_d   = pick_sts ? {8'h00, drop_q, mismatch_packets, total_packets} : buf_q;
          state_d   = pick_sts ? StSendSts : StSendTlm;
          // Loading the header on the grant cycle keeps frames back-to-back.
          if (load_ok) begin
            emit      = 1'b1;
            emit_word = pick_sts ? STS_HEADER : TLM_HEADER;
            idx_d     = 3'd1;
`ifdef FT_TX_SCHED_CHECKSUM_EN
            csum_d    = emit_word;
`endif
          end else begin
            idx_d     = 3'd0;
`ifdef FT_TX_SCHED_CHECKSUM_EN
            csum_d    = 16'h0000;
`endif
          end
        end
      end
      StSendTlm, StSendSts: begin
        if (load_ok) begin
          emit      = 1'b1;
          emit_word = cur_word;
`ifdef FT_TX_SCHED_CHECKSUM_EN
          csum_d    = csum_q + cur_word;
`endif
          if (idx_q == last_idx) begin
`ifdef FT_TX_SCHED_CHECKSUM_EN
            state_d = StSendCsum;
`else
            state_d = StIdle;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
`ifdef FT_TX_SCHED_CHECKSUM_EN
      StSendCsum: begin
        if (load_ok) begin
          emit      = 1'b1;
          emit_word = csum_q;
          state_d   = StIdle;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // Input buffer, drop counter and status timer.
  always_comb begin
    buf_full_d = buf_full_q;
    buf_d      = buf_q;
    drop_d     = drop_q;
    if (packet_valid && (!buf_full_q || grant_tlm)) begin
      buf_full_d = 1'b1;
      buf_d      = packet_data;
    end else if (grant_tlm) begin
      buf_full_d = 1'b0;
    end
    if (packet_valid && buf_full_q && !grant_tlm && (drop_q != 16'hFFFF)) begin
      drop_d = drop_q + 16'd1;
    end

    sts_pend_d = (sts_pend_q && !grant_sts) || timer_tc;
    if (STATUS_PERIOD == 32'd0 || timer_tc) begin
      period_d = 32'd0;
    end else begin
      period_d = period_q + 32'd1;
    end

    dout_d   = dout_q;
    dvalid_d = dvalid_q;
    if (load_ok) begin
      dvalid_d = emit;
      if (emit) begin
        dout_d = emit_word;
      end
    end
  end

  always_ff @(posedge clk_128M) begin
    if (rst_128M) begin
      state_q    <= StIdle;
      idx_q      <= 3'd0;
      frame_q    <= '0;
      ftype_q    <= 1'b0;
      rr_q       <= 1'b0;
      buf_full_q <= 1'b0;
      buf_q      <= '0;
      sts_pend_q <= 1'b0;
      period_q   <= 32'd0;
      drop_q     <= 16'h0000;
      dout_q     <= 16'h0000;
      dvalid_q   <= 1'b0;
`ifdef FT_TX_SCHED_CHECKSUM_EN
      csum_q     <= 16'h0000;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      frame_q    <= frame_d;
      ftype_q    <= ftype_d;
      rr_q       <= rr_d;
      buf_full_q <= buf_full_d;
      buf_q      <= buf_d;
      sts_pend_q <= sts_pend_d;
      period_q   <= period_d;
      drop_q     <= drop_d;
      dout_q     <= dout_d;
      dvalid_q   <= dvalid_d;
`ifdef FT_TX_SCHED_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign tx.ui_din       = dout_q;
  assign tx.ui_din_be    = 2'b11;
  assign tx.ui_din_valid = dvalid_q;
  assign drop_count      = drop_q;
  assign busy            = (state_q != StIdle);

endmodule
